// File: rtl/ic_refill_if.sv
// Signal bundle between the icache refill engine, the icache and the memory port.
// master: the refill engine; slave: the icache/memory side that drives requests and read data.
interface ic_refill_if;
    logic         irq;
    logic [31:0]  if_addr;
    logic         ext_busy;
    logic         L2_busy;
    logic         L2_rdy;
    logic         complete;
    logic [127:0] data_wd;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic         err;

    modport master (
        input  irq, if_addr, ext_busy, mem_rdata, mem_ack,
        output L2_busy, L2_rdy, complete, data_wd, mem_req, mem_addr, err
    );

    modport slave (
        output irq, if_addr, ext_busy, mem_rdata, mem_ack,
        input  L2_busy, L2_rdy, complete, data_wd, mem_req, mem_addr, err
    );
endinterface

// File: rtl/ic_refill.sv
// Icache line refill engine: fetches four 32-bit words, re-issuing a word after TIMEOUT_CYC idle cycles.
// IC_REFILL_CRITWORD_EN: start at the missed word and wrap; otherwise always fetch words 0..3.
module ic_refill #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_tmp,
    input  logic        rst,
    ic_refill_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] RETRY = 3'd2;
    localparam logic [2:0] RDY   = 3'd3;
    localparam logic [2:0] WR    = 3'd4;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]       state;
    logic [27:0]      line;
    logic [1:0]       cnt;
    logic [1:0]       wptr;
    logic [TW-1:0]    tcnt;
    logic [3:0][31:0] words;
    logic [1:0]       start_w;
    logic             unused_bits;

`ifdef IC_REFILL_CRITWORD_EN
    assign start_w     = bus.if_addr[3:2];
    assign unused_bits = ^bus.if_addr[1:0];
`else
    assign start_w     = 2'd0;
    assign unused_bits = ^bus.if_addr[3:0];
`endif

    always_ff @(posedge clk_tmp) begin
        if (rst) begin
            state <= IDLE;
            line  <= '0;
            cnt   <= '0;
            wptr  <= '0;
            tcnt  <= '0;
            words <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.irq && !bus.ext_busy) begin
                        line  <= bus.if_addr[31:4];
                        cnt   <= '0;
                        wptr  <= start_w;
                        tcnt  <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        // slot follows the word index, so fetch order never changes the line image
                        words[wptr] <= bus.mem_rdata;
                        wptr        <= wptr + 2'd1;
                        cnt         <= cnt + 2'd1;
                        tcnt        <= '0;
                        if (cnt == 2'd3)
                            state <= RDY;
                    end else if (tcnt == TLAST) begin
                        tcnt  <= '0;
                        state <= RETRY;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RETRY:   state <= FETCH;
                RDY:     state <= WR;
                WR:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.L2_busy  = (state != IDLE) || bus.ext_busy;
    assign bus.mem_req  = (state == FETCH);
    assign bus.mem_addr = {line, wptr, 2'b00};
    assign bus.L2_rdy   = (state == RDY);
    assign bus.complete = (state == WR);
    assign bus.err      = (state == RETRY);
    assign bus.data_wd  = words;
endmodule

// File: tb/tb_ic_refill.sv
// Scoreboard bench for ic_refill: stimulus pushes expected word addresses, lines and timeouts;
// a negedge monitor pops and compares whenever the engine acks a word, pulses L2_rdy or err.
module tb_ic_refill;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ic_refill_if bus();
    ic_refill #(.TIMEOUT_CYC(4)) dut (.clk_tmp(clk), .rst(rst), .bus(bus.master));

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    logic [31:0]  exp_addr[$];
    logic [127:0] exp_line[$];
    logic [31:0]  exp_err[$];

    logic        ack_always = 1'b0;
    logic [31:0] nack_addr  = '0;
    int          nack_cnt   = 0;
    logic        mon_en     = 1'b0;
    logic        prev_err   = 1'b0;
    logic        prev_rdy   = 1'b0;
    logic [31:0] last_addr  = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] waddr(input logic [31:0] a, input int i);
        logic [1:0] s;
`ifdef IC_REFILL_CRITWORD_EN
        s = a[3:2];
`else
        s = 2'd0;
`endif
        s = s + 2'(i);
        return {a[31:4], s, 2'b00};
    endfunction

    task automatic push_words(input logic [31:0] a);
        for (int i = 0; i < 4; i++) exp_addr.push_back(waddr(a, i));
    endtask

    // returns at #1 after the edge where L2_rdy (sel=0) or complete (sel=1) is seen
    task automatic wait_for(input int sel, input string name);
        for (int n = 0; n < 100; n++) begin
            if ((sel == 0) ? bus.L2_rdy : bus.complete) return;
            tick();
        end
        flag(name);
    endtask

    // memory model: acks every request with rdata = address, except programmed refusals
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            tick();
            if (ack_always) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end else if (bus.mem_req) begin
                if (nack_cnt > 0 && bus.mem_addr == nack_addr) begin
                    nack_cnt--;
                    bus.mem_ack = 1'b0;
                end else begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.mem_req && bus.mem_ack) begin
                    if (exp_addr.size() == 0) flag("unexpected_word_ack");
                    else chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
                end
                if (bus.mem_req) last_addr = bus.mem_addr;
                if (bus.err) begin
                    err_cnt++;
                    chk("err_mem_req_low", bus.mem_req, 1'b0);
                    if (prev_err) flag("err_longer_than_1");
                    if (exp_err.size() == 0) flag("unexpected_err");
                    else chk("err_addr", last_addr, exp_err.pop_front());
                end
                if (prev_rdy) chk("complete_after_rdy", bus.complete, 1'b1);
                else if (bus.complete) flag("unexpected_complete");
                if (bus.L2_rdy) begin
                    if (prev_rdy) flag("L2_rdy_longer_than_1");
                    if (exp_line.size() == 0) flag("unexpected_L2_rdy");
                    else chk("data_wd", bus.data_wd, exp_line.pop_front());
                end
                prev_err = bus.err;
                prev_rdy = bus.L2_rdy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        failures++;
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int e0;
        rst          = 1'b1;
        bus.irq      = 1'b0;
        bus.if_addr  = '0;
        bus.ext_busy = 1'b0;
        repeat (3) tick();
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_L2_rdy", bus.L2_rdy, 1'b0);
        chk("rst_complete", bus.complete, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_L2_busy", bus.L2_busy, 1'b0);
        chk("rst_data_wd", bus.data_wd, 128'h0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // basic line, hand-computed order and image
`ifdef IC_REFILL_CRITWORD_EN
        exp_addr.push_back(32'h1238); exp_addr.push_back(32'h123C);
        exp_addr.push_back(32'h1230); exp_addr.push_back(32'h1234);
`else
        exp_addr.push_back(32'h1230); exp_addr.push_back(32'h1234);
        exp_addr.push_back(32'h1238); exp_addr.push_back(32'h123C);
`endif
        exp_line.push_back(128'h0000123C_00001238_00001234_00001230);
        bus.if_addr = 32'h0000_1238;
        bus.irq     = 1'b1;
        lat = 0;
        while (!bus.L2_rdy && lat < 50) begin
            tick();
            lat++;
        end
        chk("min_latency", 32'(lat), 32'd5);
        bus.irq = 1'b0;
        wait_for(1, "timeout_complete_A");
        tick();
        chk("idle_L2_busy", bus.L2_busy, 1'b0);

        // acks while idle must not disturb the held line
        ack_always = 1'b1;
        repeat (3) tick();
        ack_always = 1'b0;
        tick();
        chk("ack_outside_fetch", bus.data_wd, 128'h0000123C_00001238_00001234_00001230);

        // irq held off by ext_busy
        push_words(32'h0000_4000);
        exp_line.push_back(128'h0000400C_00004008_00004004_00004000);
        bus.if_addr  = 32'h0000_4000;
        bus.ext_busy = 1'b1;
        bus.irq      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ext_busy_mem_req", bus.mem_req, 1'b0);
            chk("ext_busy_L2_busy", bus.L2_busy, 1'b1);
        end
        bus.ext_busy = 1'b0;
        tick();
        chk("fetch_after_ext_busy", bus.mem_req, 1'b1);
        wait_for(0, "timeout_rdy_B");
        bus.irq = 1'b0;
        wait_for(1, "timeout_complete_B");
        tick();

        // four refused cycles on word 1 -> err, RETRY, re-issue
        e0 = err_cnt;
        push_words(32'h0000_2000);
        exp_line.push_back(128'h0000200C_00002008_00002004_00002000);
        exp_err.push_back(32'h0000_2004);
        nack_addr   = 32'h0000_2004;
        nack_cnt    = 4;
        bus.if_addr = 32'h0000_2000;
        bus.irq     = 1'b1;
        wait_for(0, "timeout_rdy_C");
        bus.irq = 1'b0;
        wait_for(1, "timeout_complete_C");
        tick();
        chk("err_pulse_count", 32'(err_cnt - e0), 32'd1);

        // reset after two words: third ack lands on the reset edge and is dropped
        exp_addr.push_back(32'h3000); exp_addr.push_back(32'h3004); exp_addr.push_back(32'h3008);
        bus.if_addr = 32'h0000_3000;
        bus.irq     = 1'b1;
        repeat (3) tick();
        rst     = 1'b1;
        bus.irq = 1'b0;
        tick();
        chk("midrst_mem_req", bus.mem_req, 1'b0);
        chk("midrst_L2_busy", bus.L2_busy, 1'b0);
        chk("midrst_L2_rdy", bus.L2_rdy, 1'b0);
        chk("midrst_complete", bus.complete, 1'b0);
        chk("midrst_err", bus.err, 1'b0);
        chk("midrst_data_wd", bus.data_wd, 128'h0);
        rst = 1'b0;
        tick();
        push_words(32'h0000_3000);
        exp_line.push_back(128'h0000300C_00003008_00003004_00003000);
        bus.irq = 1'b1;
        wait_for(0, "timeout_rdy_D");
        bus.irq = 1'b0;
        wait_for(1, "timeout_complete_D");
        tick();

        // if_addr moves and irq drops after acceptance
        push_words(32'h0000_5004);
        exp_line.push_back(128'h0000500C_00005008_00005004_00005000);
        bus.if_addr = 32'h0000_5004;
        bus.irq     = 1'b1;
        repeat (2) tick();
        bus.if_addr = 32'hFFFF_FFF0;
        bus.irq     = 1'b0;
        wait_for(0, "timeout_rdy_E");
        wait_for(1, "timeout_complete_E");
        tick();

        // irq held through WR starts the next refill from the current if_addr
        push_words(32'h0000_6000);
        push_words(32'h0000_7000);
        exp_line.push_back(128'h0000600C_00006008_00006004_00006000);
        exp_line.push_back(128'h0000700C_00007008_00007004_00007000);
        bus.if_addr = 32'h0000_6000;
        bus.irq     = 1'b1;
        wait_for(0, "timeout_rdy_F1");
        bus.if_addr = 32'h0000_7000;
        tick();
        tick();
        chk("b2b_idle_L2_busy", bus.L2_busy, 1'b0);
        tick();
        chk("b2b_restart_mem_req", bus.mem_req, 1'b1);
        wait_for(0, "timeout_rdy_F2");
        bus.irq = 1'b0;
        wait_for(1, "timeout_complete_F2");
        repeat (3) tick();

        chk("exp_addr_drained", 32'(exp_addr.size()), 32'd0);
        chk("exp_line_drained", 32'(exp_line.size()), 32'd0);
        chk("exp_err_drained", 32'(exp_err.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ic_refill.md
IC_REFILL -- requirements
Module: ic_refill

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for mem_ack on one word before re-issuing that word.
REQ-002 clk_tmp  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 irq  input  1  icache refill request, level, held until L2_rdy is seen.
REQ-005 if_addr  input  32  miss address from icache; bits [31:4] select the line, bits [3:2] select the missed word.
REQ-006 ext_busy  input  1  L2 port in use by another requester.
REQ-007 L2_busy  output  1  refill engine or L2 port unavailable.
REQ-008 L2_rdy  output  1  one-cycle pulse: the 128-bit line is assembled.
REQ-009 complete  output  1  one-cycle pulse: the L1 write is done.
REQ-010 data_wd  output  128  line write data to L1 data0/data1; word n occupies bits [32n+31:32n].
REQ-011 mem_req  output  1  memory word-read request.
REQ-012 mem_addr  output  32  word address {line[31:4], word[1:0], 2'b00}.
REQ-013 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-014 mem_ack  input  1  one-cycle acknowledge that mem_rdata is valid.
REQ-015 err  output  1  one-cycle pulse on each word timeout.

Function
REQ-016 States SHALL be IDLE, FETCH, RETRY, RDY, WR.
REQ-017 L2_busy SHALL equal (state != IDLE) OR ext_busy, combinationally.
REQ-018 IDLE: when irq=1 and ext_busy=0, the block SHALL latch if_addr[31:4] into line, set the word counter cnt=0, set the word pointer to the start word, and go to FETCH; otherwise it stays in IDLE.
REQ-019 An irq arriving while ext_busy=1 SHALL wait in IDLE until ext_busy=0.
REQ-020 FETCH: mem_req=1 and mem_addr={line, wptr, 2'b00}.
REQ-021 On mem_ack in FETCH, mem_rdata SHALL be stored in data_wd word slot wptr, wptr incremented modulo 4, cnt incremented, and the timeout counter cleared.
REQ-022 When the 4th word (cnt=3) is acknowledged, the block SHALL go to RDY; mem_req SHALL be 0 in the following cycle.
REQ-023 A mem_ack outside FETCH SHALL be ignored.
REQ-024 Timeout: when TIMEOUT_CYC consecutive FETCH cycles pass without mem_ack, the block SHALL pulse err for one cycle, go to RETRY (mem_req=0 for exactly one cycle), and return to FETCH with the same wptr.
REQ-025 RDY: L2_rdy=1 for exactly one cycle, then WR.
REQ-026 WR: complete=1 for exactly one cycle, then IDLE.
REQ-027 data_wd SHALL be held stable from entry to RDY until the next line fetch starts.
REQ-028 The minimum latency from irq accepted to L2_rdy SHALL be 5 cycles, with mem_ack returned in the same cycle as each request.
REQ-029 irq deasserting mid-fetch SHALL NOT abort the refill.
REQ-030 irq still high in the cycle after WR SHALL start a new refill, using the current if_addr.
REQ-031 The line address SHALL be frozen after acceptance; later if_addr changes are ignored until IDLE.

Reset
REQ-032 When rst=1 at a clock edge, state SHALL become IDLE and mem_req, L2_rdy, complete, and err SHALL be 0.
REQ-033 The same rst edge SHALL set data_wd to 0 and clear cnt, wptr, line, and the timeout counter.
REQ-034 rst SHALL take priority over all other inputs; rst during FETCH SHALL abandon the refill with no L2_rdy or complete.
REQ-035 The engine SHALL capture no mem_ack arriving at the same edge as rst.

Configuration
REQ-036 Macro IC_REFILL_CRITWORD_EN SHALL select the start word and fetch order.
- Defined: start wptr=if_addr[3:2], wrap order (e.g. 2,3,0,1).
- Undefined: start wptr=0, order 0,1,2,3 regardless of if_addr[3:2].
- Either way, data_wd slot placement SHALL be by word index, so the line content is identical.

Verification
REQ-037 if_addr=0x0000_1238 with irq=1, ext_busy=0, and mem_ack every cycle with rdata=addr -> mem_addr sequence:
- Macro undefined: 0x1230, 0x1234, 0x1238, 0x123C.
- Macro defined: 0x1238, 0x123C, 0x1230, 0x1234.
- Either way: data_wd=0x0000123C_00001238_00001234_00001230, L2_rdy pulses 1 cycle, and complete pulses the next cycle.
REQ-038 ext_busy=1 for 10 cycles while irq=1 -> mem_req stays 0 and L2_busy=1; the fetch begins the cycle after ext_busy falls.
REQ-039 TIMEOUT_CYC=4 with no mem_ack on word 1 -> after 4 FETCH cycles:
- err pulses once and mem_req drops for 1 cycle.
- The same mem_addr is re-issued; completion is still correct after the ack.
REQ-040 rst asserted after 2 words acked -> next cycle state=IDLE, all outputs 0, data_wd=0; a new irq refetches all 4 words.
REQ-041 if_addr changed to 0xFFFF_FFF0 mid-fetch and irq dropped -> the original line completes with unchanged mem_addr values and L2_rdy/complete still pulse.
